tdm_mux: RTL and testbench
==========================

# tdm_mux

Parametrised, registered N:1 multiplexer: the successor to the gate-level 4:1 mux. It selects one WIDTH-bit lane out of CH channels and supports two modes. In manual mode an external select picks the lane. In scan mode an internal round-robin sequencer steps through the channels, holding each for DWELL cycles. The block sits between parallel channel sources and a single serial consumer, and reports which channel is on the output and where each scan frame begins.

## Interface
- WIDTH, 1: bits per channel.
- CH, 4: channel count, ≥2, need not be a power of two.
- DWELL, 1: cycles each channel is held in scan mode, ≥1.
- SW (localparam), $clog2(CH): select and pointer width.

- clk, in, 1: single clock; all logic on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- in, in, CH*WIDTH: channel k occupies in[k*WIDTH +: WIDTH].
- sel, in, SW: manual-mode channel select.
- mode, in, 1: 0 = manual, 1 = scan.
- en, in, 1: sample enable. When low, the block freezes.
- out, out, WIDTH: registered selected lane.
- ch, out, SW: index of the channel currently on out.
- out_valid, out, 1: high when out was updated this cycle.
- frame, out, 1: one-cycle pulse on the first valid sample of each scan frame.

## Operation
- Reset (rst=1 at an edge): out=0, ch=0, out_valid=0, frame=0, pointer p=0, dwell count d=0, registered mode copy=0. Reset overrides en and mode.
- Manual mode, en=1, sel<CH: out←in[sel], ch←sel, out_valid←1, frame←0.
- Manual mode, en=1, sel≥CH: out and ch hold, out_valid←0.
- Scan mode, en=1: out←in[p], ch←p, out_valid←1. Then:
  - if d==DWELL-1: d←0 and p←(p==CH-1 ? 0 : p+1);
  - otherwise d←d+1.
- frame←1 on the first valid scan sample after scan entry and on the first valid sample after p wraps. It is 0 otherwise.
- en=0 in either mode: out, ch, p and d hold; out_valid←0; frame←0.
- Mode change, detected against the registered mode copy: p←0 and d←0. The transition cycle already operates in the new mode, starting from p=0. Entering scan therefore asserts frame on its first valid sample.
- Arithmetic:
  - d is a $clog2(DWELL+1)-bit counter;
  - p wraps explicitly at CH-1, never by natural overflow, so non-power-of-two CH is correct.

## Timing
- Latency is 1 cycle, input to out/ch/out_valid, in both modes.
- No combinational path from any input to any output.
- Scan period is CH×DWELL enabled cycles per frame.
- A simultaneous rst and mode change resolves as reset.
- A simultaneous mode change and en=0 still clears p and d.
- Reset mid-scan: the next enabled scan cycle outputs channel 0 with frame=1.

## Configuration
- MUX_SKIP_MASK_EN defined:
  - adds input mask, CH bits;
  - in scan mode, a channel with mask[p]=0 produces no sample (out/ch hold, out_valid=0), and p advances immediately with d←0;
  - frame marks the first valid sample after a wrap;
  - with mask all-zero, out_valid stays 0 and p keeps cycling;
  - manual mode with mask[sel]=0 behaves as sel≥CH.
- Not defined: no mask port; every channel is sampled.

## Structure
- Shared package mux_pkg:
  - mode constants MODE_MANUAL=1'b0 and MODE_SCAN=1'b1;
  - function next_ch(p, CH) for wrap-around;
  - lane-slice helper.
- One sub-module, mux_dwell_cnt: the DWELL counter with en, clr and a terminal-count output. The top level owns the pointer, the mode register and the output registers.

## Test plan
- Manual select, WIDTH=1, CH=4, in=4'b1010, mode=0, en=1, sel stepping 0,1,2,3 one per cycle → out 0,1,0,1 and ch 0,1,2,3, each one cycle after sel; out_valid=1 throughout.
- Scan with dwell, DWELL=2, in=4'b1010, mode=1 → ch 0,0,1,1,2,2,3,3,0; out 0,0,1,1,0,0,1,1,0; frame high on the 1st and 9th samples only.
- Enable gating, scan DWELL=1, en low for 3 cycles after ch=1 → out/ch hold at 1 with out_valid=0 and frame=0; on re-enable the next sample is ch=2.
- Reset and mode switch:
  - rst pulsed mid-frame at ch=2 → all outputs 0 the next cycle, then ch=0 with frame=1;
  - manual→scan switch while p=3 → next sample is ch=0 with frame=1.
- Out-of-range select, CH=3, sel=3 in manual → out/ch hold, out_valid=0.
- Mask (MUX_SKIP_MASK_EN), CH=4, DWELL=1, mask=4'b0101 → valid samples ch 0,2,0,2 with gaps of out_valid=0 between them; frame on each ch=0 sample; with mask=0, out_valid never asserts.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the tdm_mux block: mode encoding, pointer wrap and lane slicing.
package mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // Explicit wrap at n-1 so channel counts that are not a power of two work.
    function automatic int next_ch(input int p, input int n);
        return (p == n - 1) ? 0 : p + 1;
    endfunction

    function automatic int lane_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/mux_dwell_cnt.sv
// Dwell counter for the scan sequencer; clr restarts the count from zero in the same cycle.
module mux_dwell_cnt
    import mux_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int DW = $clog2(DWELL + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DWELL - 1);

    logic [DW-1:0] d_q;
    logic [DW-1:0] d_d;
    logic [DW-1:0] d_eff;

    // tc reflects the count this cycle operates on, so a clear takes effect immediately.
    always_comb begin
        d_eff = clr ? '0 : d_q;
        tc    = (d_eff == D_LAST);
        d_d   = d_eff;
        if (en) begin
            d_d = tc ? '0 : d_eff + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= '0;
        end else begin
            d_q <= d_d;
        end
    end

endmodule

// File: rtl/tdm_mux.sv
// Registered CH:1 lane multiplexer with manual select and round-robin scan modes.
// Optional per-channel skip mask enabled by defining MUX_SKIP_MASK_EN.
module tdm_mux
    import mux_pkg::*;
#(
    parameter  int WIDTH = 1,
    parameter  int CH    = 4,
    parameter  int DWELL = 1,
    localparam int SW    = $clog2(CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH*WIDTH-1:0]   in,
    input  logic [SW-1:0]         sel,
    input  logic                  mode,
    input  logic                  en,
`ifdef MUX_SKIP_MASK_EN
    input  logic [CH-1:0]         mask,
`endif
    output logic [WIDTH-1:0]      out,
    output logic [SW-1:0]         ch,
    output logic                  out_valid,
    output logic                  frame
);

    localparam logic [SW-1:0] P_LAST = SW'(CH - 1);
    localparam logic [SW:0]   CH_L   = (SW + 1)'(CH);

    mode_e             mode_q;
    logic [SW-1:0]     p_q, p_d, p_eff;
    logic              pend_q, pend_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic [SW-1:0]     ch_q, ch_d;
    logic              vld_q, vld_d;
    logic              frame_q, frame_d;

    logic mode_chg;
    logic scan;
    logic skip;
    logic sel_ok;
    logic wrap;
    logic tc;
    logic cnt_en;
    logic cnt_clr;

    assign mode_chg = (mode != mode_q);
    assign scan     = (mode == MODE_SCAN);
    assign p_eff    = mode_chg ? '0 : p_q;

`ifdef MUX_SKIP_MASK_EN
    assign skip   = scan && !mask[p_eff];
    assign sel_ok = ({1'b0, sel} < CH_L) && mask[sel];
`else
    assign skip   = 1'b0;
    assign sel_ok = ({1'b0, sel} < CH_L);
`endif

    // A mode change restarts the dwell count even while the block is frozen.
    assign cnt_clr = mode_chg | (en & skip);
    assign cnt_en  = en & scan & ~skip;

    mux_dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk (clk),
        .rst (rst),
        .en  (cnt_en),
        .clr (cnt_clr),
        .tc  (tc)
    );

    always_comb begin
        out_d   = out_q;
        ch_d    = ch_q;
        vld_d   = 1'b0;
        frame_d = 1'b0;
        p_d     = p_eff;
        wrap    = 1'b0;
        // Scan entry arms the frame marker for the first sample taken in scan mode.
        pend_d  = pend_q | (mode_chg & scan);
        if (en) begin
            if (!scan) begin
                if (sel_ok) begin
                    out_d = in[lane_lo(int'(sel), WIDTH) +: WIDTH];
                    ch_d  = sel;
                    vld_d = 1'b1;
                end
            end else if (skip) begin
                p_d  = SW'(next_ch(int'(p_eff), CH));
                wrap = (p_eff == P_LAST);
            end else begin
                out_d   = in[lane_lo(int'(p_eff), WIDTH) +: WIDTH];
                ch_d    = p_eff;
                vld_d   = 1'b1;
                frame_d = pend_d;
                pend_d  = 1'b0;
                if (tc) begin
                    p_d  = SW'(next_ch(int'(p_eff), CH));
                    wrap = (p_eff == P_LAST);
                end
            end
            if (wrap) begin
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_MANUAL;
            p_q     <= '0;
            pend_q  <= 1'b1;
            out_q   <= '0;
            ch_q    <= '0;
            vld_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            mode_q  <= mode_e'(mode);
            p_q     <= p_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
            ch_q    <= ch_d;
            vld_q   <= vld_d;
            frame_q <= frame_d;
        end
    end

    assign out       = out_q;
    assign ch        = ch_q;
    assign out_valid = vld_q;
    assign frame     = frame_q;

endmodule

// File: tb/tb_tdm_mux.sv
// Bench for tdm_mux: directed scenarios on three configurations plus a randomized run
// against a frame-counting reference model. Mask scenarios compile when MUX_SKIP_MASK_EN is set.
module tb_tdm_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // A: WIDTH=1, CH=4, DWELL=1
    logic       rst_a, mode_a, en_a;
    logic [3:0] in_a;
    logic [1:0] sel_a;
    logic       out_a, vld_a, frame_a;
    logic [1:0] ch_a;
    // B: WIDTH=1, CH=4, DWELL=2
    logic       rst_b, mode_b, en_b;
    logic [3:0] in_b;
    logic [1:0] sel_b;
    logic       out_b, vld_b, frame_b;
    logic [1:0] ch_b;
    // C: WIDTH=8, CH=3, DWELL=2
    logic        rst_c, mode_c, en_c;
    logic [23:0] in_c;
    logic [1:0]  sel_c;
    logic [7:0]  out_c;
    logic        vld_c, frame_c;
    logic [1:0]  ch_c;
`ifdef MUX_SKIP_MASK_EN
    logic [3:0] mask_a;
    logic [3:0] mask_b;
    logic [2:0] mask_c;
`endif

    tdm_mux #(.WIDTH(1), .CH(4), .DWELL(1)) u_a (
        .clk(clk), .rst(rst_a), .in(in_a), .sel(sel_a), .mode(mode_a), .en(en_a),
`ifdef MUX_SKIP_MASK_EN
        .mask(mask_a),
`endif
        .out(out_a), .ch(ch_a), .out_valid(vld_a), .frame(frame_a));

    tdm_mux #(.WIDTH(1), .CH(4), .DWELL(2)) u_b (
        .clk(clk), .rst(rst_b), .in(in_b), .sel(sel_b), .mode(mode_b), .en(en_b),
`ifdef MUX_SKIP_MASK_EN
        .mask(mask_b),
`endif
        .out(out_b), .ch(ch_b), .out_valid(vld_b), .frame(frame_b));

    tdm_mux #(.WIDTH(8), .CH(3), .DWELL(2)) u_c (
        .clk(clk), .rst(rst_c), .in(in_c), .sel(sel_c), .mode(mode_c), .en(en_c),
`ifdef MUX_SKIP_MASK_EN
        .mask(mask_c),
`endif
        .out(out_c), .ch(ch_c), .out_valid(vld_c), .frame(frame_c));

    // Reference model for C: scan position derives from the number of enabled scan
    // cycles since scan entry or reset.
    logic [7:0] m_out;
    int         m_ch;
    logic       m_vld, m_frame, m_prev_mode;
    int         m_k;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_c_step();
        int c;
        if (rst_c) begin
            m_out = 8'd0; m_ch = 0; m_vld = 1'b0; m_frame = 1'b0;
            m_prev_mode = 1'b0; m_k = 0;
        end else begin
            if (mode_c != m_prev_mode) m_k = 0;
            m_prev_mode = mode_c;
            m_frame = 1'b0;
            m_vld   = 1'b0;
            if (en_c) begin
                if (!mode_c) begin
                    if (sel_c < 3) begin
                        m_ch  = int'(sel_c);
                        m_out = in_c[m_ch*8 +: 8];
                        m_vld = 1'b1;
                    end
                end else begin
                    c       = (m_k / 2) % 3;
                    m_ch    = c;
                    m_out   = in_c[c*8 +: 8];
                    m_vld   = 1'b1;
                    m_frame = ((m_k % 6) == 0);
                    m_k     = (m_k + 1) % 6;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_a = 1; rst_b = 1; rst_c = 1;
        mode_a = 1; mode_b = 1; mode_c = 1;
        en_a = 1; en_b = 1; en_c = 1;
        in_a = 4'hF; in_b = 4'hF; in_c = 24'hFFFFFF;
        tick();
        n_checks++;
        if ({out_a, ch_a, vld_a, frame_a} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_a: out=%0d ch=%0d valid=%0d frame=%0d, want all 0", out_a, ch_a, vld_a, frame_a);
        end
        n_checks++;
        if ({out_b, ch_b, vld_b, frame_b} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_b: out=%0d ch=%0d valid=%0d frame=%0d, want all 0", out_b, ch_b, vld_b, frame_b);
        end
        n_checks++;
        if ({out_c, ch_c, vld_c, frame_c} !== 12'b0) begin
            n_fail++;
            $display("FAIL reset_c: out=%0d ch=%0d valid=%0d frame=%0d, want all 0", out_c, ch_c, vld_c, frame_c);
        end
        rst_a = 0; rst_b = 0; rst_c = 0;
        mode_a = 0; mode_b = 0; mode_c = 0;
        en_a = 0; en_b = 0; en_c = 0;
        tick();
    endtask

    task automatic test_manual();
        int exp_out[4] = '{0, 1, 0, 1};
        in_a = 4'b1010; mode_a = 0; en_a = 1;
        for (int i = 0; i < 4; i++) begin
            sel_a = 2'(i);
            tick();
            n_checks++;
            if (ch_a !== 2'(i) || out_a !== 1'(exp_out[i]) || vld_a !== 1'b1 || frame_a !== 1'b0) begin
                n_fail++;
                $display("FAIL manual_sel%0d: ch=%0d out=%0d valid=%0d frame=%0d, want ch=%0d out=%0d valid=1 frame=0",
                         i, ch_a, out_a, vld_a, frame_a, i, exp_out[i]);
            end
        end
    endtask

    task automatic test_enable_gating();
        mode_a = 1; en_a = 1; in_a = 4'b1010;
        tick();
        n_checks++;
        if (ch_a !== 2'd0 || out_a !== 1'b0 || vld_a !== 1'b1 || frame_a !== 1'b1) begin
            n_fail++;
            $display("FAIL gate_first: ch=%0d out=%0d valid=%0d frame=%0d, want ch=0 out=0 valid=1 frame=1", ch_a, out_a, vld_a, frame_a);
        end
        tick();
        n_checks++;
        if (ch_a !== 2'd1 || out_a !== 1'b1 || vld_a !== 1'b1 || frame_a !== 1'b0) begin
            n_fail++;
            $display("FAIL gate_second: ch=%0d out=%0d valid=%0d frame=%0d, want ch=1 out=1 valid=1 frame=0", ch_a, out_a, vld_a, frame_a);
        end
        en_a = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (ch_a !== 2'd1 || out_a !== 1'b1 || vld_a !== 1'b0 || frame_a !== 1'b0) begin
                n_fail++;
                $display("FAIL gate_hold%0d: ch=%0d out=%0d valid=%0d frame=%0d, want ch=1 out=1 valid=0 frame=0", i, ch_a, out_a, vld_a, frame_a);
            end
        end
        en_a = 1;
        tick();
        n_checks++;
        if (ch_a !== 2'd2 || out_a !== 1'b0 || vld_a !== 1'b1 || frame_a !== 1'b0) begin
            n_fail++;
            $display("FAIL gate_resume: ch=%0d out=%0d valid=%0d frame=%0d, want ch=2 out=0 valid=1 frame=0", ch_a, out_a, vld_a, frame_a);
        end
    endtask

    task automatic test_reset_mid_scan();
        rst_a = 1;
        tick();
        n_checks++;
        if ({out_a, ch_a, vld_a, frame_a} !== 5'b0) begin
            n_fail++;
            $display("FAIL midreset_clear: out=%0d ch=%0d valid=%0d frame=%0d, want all 0", out_a, ch_a, vld_a, frame_a);
        end
        rst_a = 0;
        tick();
        n_checks++;
        if (ch_a !== 2'd0 || vld_a !== 1'b1 || frame_a !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_restart: ch=%0d valid=%0d frame=%0d, want ch=0 valid=1 frame=1", ch_a, vld_a, frame_a);
        end
    endtask

    task automatic test_mode_switch();
        mode_a = 0; sel_a = 2'd3; en_a = 1; in_a = 4'b1010;
        tick();
        n_checks++;
        if (ch_a !== 2'd3 || out_a !== 1'b1 || vld_a !== 1'b1) begin
            n_fail++;
            $display("FAIL switch_manual: ch=%0d out=%0d valid=%0d, want ch=3 out=1 valid=1", ch_a, out_a, vld_a);
        end
        mode_a = 1;
        tick();
        n_checks++;
        if (ch_a !== 2'd0 || out_a !== 1'b0 || vld_a !== 1'b1 || frame_a !== 1'b1) begin
            n_fail++;
            $display("FAIL switch_scan: ch=%0d out=%0d valid=%0d frame=%0d, want ch=0 out=0 valid=1 frame=1", ch_a, out_a, vld_a, frame_a);
        end
    endtask

    task automatic test_scan_dwell();
        int exp_ch[9]  = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        int exp_out[9] = '{0, 0, 1, 1, 0, 0, 1, 1, 0};
        logic exp_fr;
        in_b = 4'b1010; mode_b = 1; en_b = 1;
        for (int i = 0; i < 9; i++) begin
            tick();
            exp_fr = (i == 0 || i == 8);
            n_checks++;
            if (ch_b !== 2'(exp_ch[i]) || out_b !== 1'(exp_out[i]) || vld_b !== 1'b1 || frame_b !== exp_fr) begin
                n_fail++;
                $display("FAIL scan_dwell%0d: ch=%0d out=%0d valid=%0d frame=%0d, want ch=%0d out=%0d valid=1 frame=%0d",
                         i, ch_b, out_b, vld_b, frame_b, exp_ch[i], exp_out[i], exp_fr);
            end
        end
        en_b = 0;
    endtask

    task automatic test_out_of_range();
        logic [23:0] first_in;
        rst_c = 1; tick(); rst_c = 0;
        mode_c = 0; en_c = 1; sel_c = 2'd1;
        first_in = 24'($urandom);
        in_c = first_in;
        tick();
        n_checks++;
        if (ch_c !== 2'd1 || out_c !== first_in[15:8] || vld_c !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_valid_sel: ch=%0d out=%0h valid=%0d, want ch=1 out=%0h valid=1", ch_c, out_c, vld_c, first_in[15:8]);
        end
        sel_c = 2'd3;
        in_c = ~first_in;
        tick();
        n_checks++;
        if (ch_c !== 2'd1 || out_c !== first_in[15:8] || vld_c !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_hold: ch=%0d out=%0h valid=%0d, want ch=1 out=%0h valid=0", ch_c, out_c, vld_c, first_in[15:8]);
        end
    endtask

    task automatic test_random();
        rst_c = 1; en_c = 0; mode_c = 0;
        tick();
        model_c_step();
        rst_c = 0;
        for (int i = 0; i < 400; i++) begin
            rst_c  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) mode_c = ~mode_c;
            en_c   = ($urandom_range(0, 3) != 0);
            sel_c  = 2'($urandom_range(0, 3));
            in_c   = 24'($urandom);
            tick();
            model_c_step();
            n_checks++;
            if (out_c !== m_out || ch_c !== 2'(m_ch) || vld_c !== m_vld || frame_c !== m_frame) begin
                n_fail++;
                $display("FAIL random%0d: out=%0h ch=%0d valid=%0d frame=%0d, want out=%0h ch=%0d valid=%0d frame=%0d",
                         i, out_c, ch_c, vld_c, frame_c, m_out, m_ch, m_vld, m_frame);
            end
        end
        rst_c = 0; en_c = 0;
    endtask

`ifdef MUX_SKIP_MASK_EN
    task automatic test_mask();
        int   exp_ch[6]  = '{0, 0, 2, 2, 0, 0};
        logic exp_vld[6] = '{1, 0, 1, 0, 1, 0};
        logic exp_fr[6]  = '{1, 0, 0, 0, 1, 0};
        logic exp_out[6] = '{0, 0, 1, 1, 0, 0};
        rst_a = 1; mode_a = 1; en_a = 1; in_a = 4'b0100; mask_a = 4'b0101;
        tick();
        rst_a = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (ch_a !== 2'(exp_ch[i]) || vld_a !== exp_vld[i] || frame_a !== exp_fr[i] || out_a !== exp_out[i]) begin
                n_fail++;
                $display("FAIL mask_seq%0d: ch=%0d out=%0d valid=%0d frame=%0d, want ch=%0d out=%0d valid=%0d frame=%0d",
                         i, ch_a, out_a, vld_a, frame_a, exp_ch[i], exp_out[i], exp_vld[i], exp_fr[i]);
            end
        end
        mask_a = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (vld_a !== 1'b0 || frame_a !== 1'b0) begin
                n_fail++;
                $display("FAIL mask_zero%0d: valid=%0d frame=%0d, want valid=0 frame=0", i, vld_a, frame_a);
            end
        end
        mask_a = 4'b0101; mode_a = 0; sel_a = 2'd2;
        tick();
        n_checks++;
        if (ch_a !== 2'd2 || out_a !== 1'b1 || vld_a !== 1'b1) begin
            n_fail++;
            $display("FAIL mask_manual_ok: ch=%0d out=%0d valid=%0d, want ch=2 out=1 valid=1", ch_a, out_a, vld_a);
        end
        sel_a = 2'd1;
        tick();
        n_checks++;
        if (ch_a !== 2'd2 || out_a !== 1'b1 || vld_a !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_manual_skip: ch=%0d out=%0d valid=%0d, want ch=2 out=1 valid=0", ch_a, out_a, vld_a);
        end
        mask_a = 4'hF; en_a = 0;
    endtask
`endif

    initial begin
        rst_a = 1; rst_b = 1; rst_c = 1;
        mode_a = 0; mode_b = 0; mode_c = 0;
        en_a = 0; en_b = 0; en_c = 0;
        in_a = '0; in_b = '0; in_c = '0;
        sel_a = '0; sel_b = '0; sel_c = '0;
`ifdef MUX_SKIP_MASK_EN
        mask_a = '1; mask_b = '1; mask_c = '1;
`endif
        tick();
        test_reset();
        test_manual();
        test_enable_gating();
        test_reset_mid_scan();
        test_mode_switch();
        test_scan_dwell();
        test_out_of_range();
        test_random();
`ifdef MUX_SKIP_MASK_EN
        test_mask();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
